input_port_unit: RTL and testbench

Per-input-port front end of the 5-port mesh router. It buffers incoming flits in a small FIFO and computes the XY route of the head flit. It drives `req_port`/`rout_port` into the five switch allocators and releases one flit to the crossbar per granted cycle. One instance sits on each of the local, west, north, east and south inputs.

---
 rtl/noc_pkg.sv | 33 +++
 rtl/flit_fifo.sv | 50 +++++
 rtl/input_port_unit.sv | 110 +++++++++++
 tb/tb_input_port_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router: output port IDs, flit destination
// field layout, input-port FSM states and the XY routing rule.
package noc_pkg;

   localparam logic [2:0] PORT_LOCAL = 3'd0;
   localparam logic [2:0] PORT_WEST  = 3'd1;
   localparam logic [2:0] PORT_NORTH = 3'd2;
   localparam logic [2:0] PORT_EAST  = 3'd3;
   localparam logic [2:0] PORT_SOUTH = 3'd4;

   // Destination fields are counted down from the flit MSB: x first, then y.
   localparam int DEST_FIELD_W   = 2;
   localparam int DEST_X_MSB_OFS = 0;
   localparam int DEST_Y_MSB_OFS = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_RELEASE = 2'd2
   } ipu_state_e;

   function automatic logic [2:0] xy_route(input logic [1:0] dx, input logic [1:0] dy,
                                           input logic [1:0] rx, input logic [1:0] ry);
      logic [2:0] port;
      if (dx > rx)      port = PORT_EAST;
      else if (dx < rx) port = PORT_WEST;
      else if (dy < ry) port = PORT_NORTH;
      else if (dy > ry) port = PORT_SOUTH;
      else              port = PORT_LOCAL;
      return port;
   endfunction

endpackage

// File: rtl/flit_fifo.sv
// First-word fall-through flit buffer; the caller guarantees no push when
// full and no pop when empty. Also exposes the entry behind the head.
module flit_fifo #(
   parameter  int FLIT_WIDTH = 16,
   parameter  int FIFO_DEPTH = 4,
   localparam int PW         = $clog2(FIFO_DEPTH),
   localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [FLIT_WIDTH-1:0] push_flit,
   input  logic                  pop,
   output logic [FLIT_WIDTH-1:0] head_flit,
   output logic [FLIT_WIDTH-1:0] second_flit,
   output logic [CW-1:0]         count,
   output logic                  full,
   output logic                  empty
);

   logic [FLIT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_flit;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign full        = (count == CW'(FIFO_DEPTH));
   assign empty       = (count == '0);
   assign head_flit   = empty ? '0 : mem[rd_ptr];
   assign second_flit = mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/input_port_unit.sv
// Router input port: buffers flits, computes the XY route of the head and
// holds a request to the switch allocators while same-route flits stream out.
module input_port_unit import noc_pkg::*; #(
   parameter int         FLIT_WIDTH = 16,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [1:0] ROUTER_X   = 2'd0,
   parameter logic [1:0] ROUTER_Y   = 2'd0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FLIT_WIDTH-1:0] in_flit,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  req_port,
   output logic [2:0]            rout_port,
   input  logic [4:0]            grant_in,
   output logic [FLIT_WIDTH-1:0] out_flit,
   output logic                  out_valid,
   output ipu_state_e            state_dbg
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   ipu_state_e            state;
   logic [2:0]            route_q;
   logic                  push;
   logic                  transfer;
   logic                  full;
   logic                  empty;
   logic [CW-1:0]         count;
   logic [FLIT_WIDTH-1:0] second_flit;
   logic [FLIT_WIDTH-1:0] next_flit;
   logic                  next_avail;
   logic [2:0]            head_route;
   logic [2:0]            next_route;

   assign in_ready  = !full;
   assign push      = in_valid && !full;
   assign transfer  = (state == ST_ACTIVE) && grant_in[route_q] && !empty;
   assign out_valid = transfer;
   assign rout_port = route_q;
   assign state_dbg = state;

   flit_fifo #(
      .FLIT_WIDTH (FLIT_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_flit   (in_flit),
      .pop         (transfer),
      .head_flit   (out_flit),
      .second_flit (second_flit),
      .count       (count),
      .full        (full),
      .empty       (empty)
   );

   // After a pop the new head is the second entry, or the flit pushed in the
   // same cycle when only one flit was held.
   assign next_avail = (count >= CW'(2)) || push;
   assign next_flit  = (count >= CW'(2)) ? second_flit : in_flit;

   assign head_route = xy_route(out_flit[FLIT_WIDTH-1-DEST_X_MSB_OFS -: DEST_FIELD_W],
                                out_flit[FLIT_WIDTH-1-DEST_Y_MSB_OFS -: DEST_FIELD_W],
                                ROUTER_X, ROUTER_Y);
   assign next_route = xy_route(next_flit[FLIT_WIDTH-1-DEST_X_MSB_OFS -: DEST_FIELD_W],
                                next_flit[FLIT_WIDTH-1-DEST_Y_MSB_OFS -: DEST_FIELD_W],
                                ROUTER_X, ROUTER_Y);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         route_q  <= PORT_LOCAL;
         req_port <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  state    <= ST_ACTIVE;
                  route_q  <= head_route;
                  req_port <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (transfer && !(next_avail && next_route == route_q)) begin
                  state    <= ST_RELEASE;
                  req_port <= 1'b0;
               end
            end
            ST_RELEASE: begin
               // One cycle with the request low lets the allocator free the output.
               if (!empty) begin
                  state    <= ST_ACTIVE;
                  route_q  <= head_route;
                  req_port <= 1'b1;
               end else begin
                  state    <= ST_IDLE;
               end
            end
            default: begin
               state    <= ST_IDLE;
               req_port <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input_port_unit.sv
// Bench for input_port_unit at router (1,1): directed scenarios plus random
// traffic, all checked cycle by cycle against a queue-based reference model.
module tb_input_port_unit;

   localparam int FW    = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [FW-1:0] in_flit;
   logic          in_valid;
   logic          in_ready;
   logic          req_port;
   logic [2:0]    rout_port;
   logic [4:0]    grant_in;
   logic [FW-1:0] out_flit;
   logic          out_valid;
   logic [1:0]    state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: buffered flits, whether a request is up, and its route.
   logic [FW-1:0] exp_q[$];
   bit            m_req;
   int            m_route;

   always #5 clk = ~clk;

   input_port_unit #(
      .FLIT_WIDTH (FW),
      .FIFO_DEPTH (DEPTH),
      .ROUTER_X   (2'd1),
      .ROUTER_Y   (2'd1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_flit   (in_flit),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .req_port  (req_port),
      .rout_port (rout_port),
      .grant_in  (grant_in),
      .out_flit  (out_flit),
      .out_valid (out_valid),
      .state_dbg (state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [FW-1:0] mk(input int dx, input int dy, input int payload);
      logic [FW-1:0] f;
      f = {dx[1:0], dy[1:0], payload[11:0]};
      return f;
   endfunction

   // XY routing at router (1,1): x first, then y; north is decreasing y.
   function automatic int ref_route(input logic [FW-1:0] f);
      int dx;
      int dy;
      dx = int'(f[15:14]);
      dy = int'(f[13:12]);
      if (dx > 1) return 3;
      if (dx < 1) return 1;
      if (dy < 1) return 2;
      if (dy > 1) return 4;
      return 0;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_req   = 1'b0;
      m_route = 0;
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, advance the model.
   task automatic run_cycle(input logic v, input logic [FW-1:0] f, input logic [4:0] g,
                            output logic acc);
      bit            e_ready;
      bit            e_xfer;
      logic [FW-1:0] e_flit;
      int            size0;
      logic [FW-1:0] head0;
      in_valid = v;
      in_flit  = f;
      grant_in = g;
      @(negedge clk);
      size0   = exp_q.size();
      head0   = (size0 > 0) ? exp_q[0] : '0;
      e_ready = (size0 < DEPTH);
      e_xfer  = m_req && g[m_route] && (size0 > 0);
      e_flit  = head0;
      check("in_ready",  32'(in_ready),  32'(e_ready));
      check("req_port",  32'(req_port),  32'(m_req));
      check("rout_port", 32'(rout_port), 32'(m_route));
      check("out_valid", 32'(out_valid), 32'(e_xfer));
      check("out_flit",  32'(out_flit),  32'(e_flit));
      acc = v && e_ready;
      if (e_xfer) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(f);
      if (m_req) begin
         if (e_xfer && !(exp_q.size() > 0 && ref_route(exp_q[0]) == m_route)) m_req = 1'b0;
      end else if (size0 > 0) begin
         m_req   = 1'b1;
         m_route = ref_route(head0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic [4:0] g);
      logic acc;
      for (int i = 0; i < n; i++) run_cycle(1'b0, '0, g, acc);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"},  32'(in_ready),  32'd1);
      check({tag, "_req_port"},  32'(req_port),  32'd0);
      check({tag, "_rout_port"}, 32'(rout_port), 32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_flit"},  32'(out_flit),  32'd0);
   endtask

   initial begin
      logic          acc;
      logic [FW-1:0] burst[5];
      int            k;
      int            dests[5][2];
      dests = '{'{0, 2}, '{1, 0}, '{1, 3}, '{1, 1}, '{2, 0}};

      // Clock/reset
      rst      = 1'b0;
      in_valid = 1'b0;
      in_flit  = '0;
      grant_in = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Single flit east, grant two cycles after the push
      run_cycle(1'b1, mk(3, 1, 12'h101), 5'b00000, acc);
      idle(2, 5'b00000);
      idle(4, 5'b01000);

      // Route table: every direction at this router
      for (int i = 0; i < 5; i++) begin
         run_cycle(1'b1, mk(dests[i][0], dests[i][1], 12'h200 + i), 5'b00000, acc);
         idle(2, 5'b00000);
         idle(3, 5'b11111);
      end

      // Back-to-back stream to one output with the grant held
      run_cycle(1'b1, mk(3, 1, 12'h301), 5'b00000, acc);
      run_cycle(1'b1, mk(3, 1, 12'h302), 5'b00000, acc);
      run_cycle(1'b1, mk(3, 1, 12'h303), 5'b00000, acc);
      idle(6, 5'b01000);

      // Route change east -> local costs a release cycle
      run_cycle(1'b1, mk(3, 1, 12'h401), 5'b00000, acc);
      run_cycle(1'b1, mk(1, 1, 12'h402), 5'b00000, acc);
      idle(8, 5'b01001);

      // Fill to depth with no grant; fifth flit held upstream
      for (int i = 0; i < 5; i++) burst[i] = mk(3, 1, 12'h500 + i);
      k = 0;
      for (int i = 0; i < 7 && k < 5; i++) begin
         run_cycle(1'b1, burst[k], 5'b00000, acc);
         if (acc) k++;
      end
      check("full_holds_fifth", 32'(k), 32'd4);
      run_cycle(1'b1, burst[4], 5'b01000, acc);
      check("full_rejects_on_pop", 32'(in_ready), 32'd1);
      run_cycle(1'b1, burst[4], 5'b00000, acc);
      idle(10, 5'b01000);

      // Asynchronous reset with two buffered flits in ACTIVE
      run_cycle(1'b1, mk(3, 1, 12'h601), 5'b00000, acc);
      run_cycle(1'b1, mk(3, 1, 12'h602), 5'b00000, acc);
      idle(2, 5'b00000);
      in_valid = 1'b0;
      grant_in = 5'b11111;
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_reset_values("midreset");
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      idle(4, 5'b11111);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         run_cycle(1'b1 & $urandom_range(0, 1), FW'($urandom),
                   5'($urandom_range(0, 31)), acc);
      end
      idle(12, 5'b11111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
